// File: rtl/spi_reg_pkg.sv
// Shared types and encodings for the SPI register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StCommit
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Single-bit flop synchroniser; exposes the two oldest stages for edge detection.
module spi_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_q_old
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q     = r_sync[STAGES-2];
  assign o_q_old = r_sync[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a bank of read/write registers.
// Frame: R/W bit, address, data, MSB first; writes commit when nCS rises.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0]  CNT_ADDR_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_CMD       = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0]  CNT_FRAME     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT       = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W    = (ADDR_W + 1)'(NUM_REGS);

  logic w_ncs, w_ncs_old, w_sclk, w_sclk_old, w_copi, w_copi_old;
  logic w_unused_copi;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .i_d(nCS), .o_q(w_ncs), .o_q_old(w_ncs_old)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(SCLK), .o_q(w_sclk), .o_q_old(w_sclk_old)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .i_d(COPI), .o_q(w_copi), .o_q_old(w_copi_old)
  );
  assign w_unused_copi = w_copi_old;

  logic w_ncs_fall, w_ncs_rise, w_bit_rise, w_bit_fall;
  assign w_ncs_fall = ~w_ncs & w_ncs_old;
  assign w_ncs_rise = w_ncs & ~w_ncs_old;
  // An nCS rise implies w_ncs is high, so the coincident SCLK edge is dropped here.
  assign w_bit_rise = w_sclk & ~w_sclk_old & ~w_ncs;
  assign w_bit_fall = ~w_sclk & w_sclk_old & ~w_ncs;

  state_e                      r_state, w_state_d;
  logic   [CNT_W-1:0]          r_cnt;
  logic   [FRAME_W-1:0]        r_shift;
  logic   [FRAME_W-1:0]        w_shift_next;
  logic   [DATA_W-1:0]         r_out;
  logic                        r_is_read;
  logic   [ADDR_W-1:0]         r_wr_addr;
  logic   [DATA_W-1:0]         r_regs [NUM_REGS];
  logic   [DATA_W-1:0]         w_rd_data;
  logic   [ADDR_W-1:0]         w_addr;
  logic                        w_commit, w_len_ok, w_in_range, w_is_write;

  assign w_shift_next = {r_shift[FRAME_W-2:0], w_copi};

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_ncs_fall) w_state_d = StCmd;
      StCmd: begin
        if (w_ncs_rise) w_state_d = StCommit;
        else if (w_bit_rise && r_cnt == CNT_ADDR_LAST) w_state_d = StData;
      end
      StData:   if (w_ncs_rise) w_state_d = StCommit;
      StCommit: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Register selected by the address completing on the current SCLK rise.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_shift_next[ADDR_W-1:0] == ADDR_W'(i)) w_rd_data = r_regs[i];
    end
  end

  assign w_addr     = r_shift[FRAME_W-2 -: ADDR_W];
  assign w_is_write = (r_shift[FRAME_W-1] == RW_WRITE);
  assign w_len_ok   = (r_cnt == CNT_FRAME);
  assign w_in_range = ({1'b0, w_addr} < NUM_REGS_W);
  assign w_commit   = (r_state == StCommit) & w_len_ok & w_is_write & w_in_range;
  assign frame_err  = (r_state == StCommit) & (~w_len_ok | (w_is_write & ~w_in_range));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_out     <= '0;
      r_is_read <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && w_ncs_fall) begin
        r_cnt     <= '0;
        r_out     <= '0;
        r_is_read <= 1'b0;
      end
      if ((r_state == StCmd || r_state == StData) && w_bit_rise) begin
        r_shift <= w_shift_next;
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == StCmd && w_bit_rise && r_cnt == CNT_ADDR_LAST) begin
        r_out     <= w_rd_data;
        r_is_read <= (w_shift_next[ADDR_W] == RW_READ);
      end
      // The fall closing the last address bit keeps the MSB on CIPO for the next rise.
      if (r_state == StData && w_bit_fall && r_cnt > CNT_CMD) begin
        r_out <= r_out << 1;
      end
      if (w_commit) r_wr_addr <= w_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && w_addr == ADDR_W'(i)) r_regs[i] <= r_shift[DATA_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign CIPO      = (r_state == StData) & r_is_read & r_out[DATA_W-1];
  assign CIPO_oe   = ~w_ncs;
  assign wr_strobe = w_commit;
  assign wr_addr   = w_commit ? w_addr : r_wr_addr;

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of addressable registers (1..2**ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 7, frame address field width.
REQ-003 SHALL have parameter DATA_W, default 8, frame data field and register width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for nCS/SCLK/COPI (>=2).
REQ-005 SHALL use one clock and an asynchronous, active-high reset; clk, rst are the only clock/reset ports.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 nCS  input  1  SPI chip select, active low, asynchronous to clk.
REQ-009 SCLK  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-010 COPI  input  1  controller-out serial data.
REQ-011 CIPO  output  1  peripheral-out serial data.
REQ-012 CIPO_oe  output  1  CIPO drive enable, high only while nCS is synchronised low.
REQ-013 regs_flat  output  NUM_REGS*DATA_W  register contents, register i at bits [i*DATA_W +: DATA_W].
REQ-014 wr_strobe  output  1  one-cycle pulse on each committed write.
REQ-015 wr_addr  output  ADDR_W  address of the last committed write, valid with wr_strobe.
REQ-016 frame_err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-017 Frame SHALL be F=1+ADDR_W+DATA_W bits, MSB first: R/W bit (1=write, 0=read), address, data.
REQ-018 All three SPI inputs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the two oldest stages.
REQ-019 FSM states SHALL be IDLE, CMD, DATA, COMMIT; IDLE->CMD on nCS fall, CMD->DATA after 1+ADDR_W SCLK rises, DATA->COMMIT on nCS rise, COMMIT->IDLE after one cycle.
REQ-020 COPI SHALL be sampled on each synchronised SCLK rise; the bit counter SHALL saturate at F+1.
REQ-021 A write SHALL commit in COMMIT only if the bit count equals F exactly and address < NUM_REGS; wr_strobe asserts in that same cycle, regs_flat updates one cycle later.
REQ-022 Reads SHALL load register[address] (0 if address >= NUM_REGS) into the output shift register on the SCLK rise completing the address field, and shift its MSB onto CIPO immediately, each subsequent bit on a synchronised SCLK fall.
REQ-023 CIPO SHALL be 0 whenever not in DATA of a read frame.
REQ-024 nCS rise with bit count != F SHALL discard the frame, pulse frame_err, and leave all registers unchanged; out-of-range write address SHALL also pulse frame_err.
REQ-025 nCS rise and SCLK rise detected in the same cycle: nCS rise SHALL take priority and that SCLK edge SHALL be ignored.
REQ-026 SCLK edges while nCS is synchronised high SHALL be ignored.
REQ-027 Supported SCLK frequency SHALL be <= clk/(2*(SYNC_STAGES+2)).

Reset
REQ-028 rst SHALL force: FSM IDLE, all registers 0, regs_flat 0, CIPO 0, CIPO_oe 0, wr_strobe 0, wr_addr 0, frame_err 0, counters 0.
REQ-029 rst mid-frame SHALL abort the frame with no commit; the next full frame after nCS toggles high->low SHALL be accepted.

Structure
REQ-030 Package spi_reg_pkg SHALL hold the FSM state enum and the R/W bit encoding constants.
REQ-031 The input synchroniser SHALL be a sub-module spi_sync (parametrised depth, one bit per instance).

Verification
REQ-032 Write 0x03=0xA5 (defaults) -> wr_strobe one pulse, wr_addr=0x03, regs_flat[31:24]=0xA5, other regs 0.
REQ-033 Write 0x01=0x3C then read 0x01 -> CIPO returns 0x3C MSB first, CIPO_oe high only during nCS low.
REQ-034 Write 0x10=0xFF (out of range) -> frame_err pulse, no wr_strobe, regs_flat unchanged; read 0x10 returns 0x00.
REQ-035 Write frame truncated at 12 bits and one extended to 17 bits -> frame_err pulse each, registers unchanged.
REQ-036 Assert rst after 9 bits of write 0x02=0x55, release, then send write 0x02=0x55 -> regs 0 after rst, 0x55 after second frame.
REQ-037 Re-run 032/033 with NUM_REGS=16, DATA_W=16, ADDR_W=4 -> write 0x0F=0xBEEF lands at bits [255:240], read returns 0xBEEF.
